delta_pu_weight_buffer: RTL and testbench

Per-PU weight prefetch buffer on the consumer side of the Delta weight controller. On `start` it fetches one delta cycle's `ENTRIES` weight words from the shared Weight SRAM through the controller's per-PU read/ready handshake. It queues the words in a small FIFO and presents them in order to the PU's processing elements over a valid/ready stream. One instance per PU; its `WB_SRAM_read`/`WB_SRAM_address` drive one slot of the controller's arrays, and `WB_SRAM_ready` comes from the matching slot.

---
 rtl/delta_pkg.sv | 17 +
 rtl/delta_pu_weight_buffer_if.sv | 38 +++
 rtl/delta_weight_fifo.sv | 61 ++++++
 rtl/delta_pu_weight_buffer.sv | 128 ++++++++++++
 tb/tb_delta_pu_weight_buffer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/delta_pkg.sv
// Shared constants and types for the Delta weight-controller consumer side.
package delta_pkg;

    localparam int unsigned MAX_WEIGHT_LEN_BYTE = 8;
    localparam int unsigned INPUT_CHANNEL       = 16;
    localparam int unsigned WEIGHT_WORD_W       = MAX_WEIGHT_LEN_BYTE * 8;
    localparam int unsigned CHANNEL_IDX_W       = $clog2(INPUT_CHANNEL);
    localparam int unsigned SRAM_ADDR_W         = 32;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_REQ   = 2'd1,
        WB_GAP   = 2'd2,
        WB_DRAIN = 2'd3
    } wbuf_state_t;

endpackage

// File: rtl/delta_pu_weight_buffer_if.sv
// Bundle of the weight-buffer control, SRAM handshake and PE stream signals.
interface delta_pu_weight_buffer_if
    import delta_pkg::*;
#(
    parameter int unsigned WORD_W = WEIGHT_WORD_W,
    parameter int unsigned IDX_W  = CHANNEL_IDX_W
) ();

    logic                   start;
    logic                   finish_cycle;
    logic                   WB_SRAM_read;
    logic [SRAM_ADDR_W-1:0] WB_SRAM_address;
    logic                   WB_SRAM_ready;
    logic [WORD_W-1:0]      WB_SRAM_data;
    logic                   w_valid;
    logic                   w_ready;
    logic [WORD_W-1:0]      w_data;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_last;
    logic                   busy;
    logic                   done;
    logic                   err;

    // master: the weight buffer itself
    modport master (
        input  start, finish_cycle, WB_SRAM_ready, WB_SRAM_data, w_ready,
        output WB_SRAM_read, WB_SRAM_address, w_valid, w_data, w_idx, w_last,
               busy, done, err
    );

    // slave: the controller / PE environment around it
    modport slave (
        output start, finish_cycle, WB_SRAM_ready, WB_SRAM_data, w_ready,
        input  WB_SRAM_read, WB_SRAM_address, w_valid, w_data, w_idx, w_last,
               busy, done, err
    );

endinterface

// File: rtl/delta_weight_fifo.sv
// Small synchronous FIFO with flush and occupancy count; head is read straight from storage.
module delta_weight_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 68
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [W-1:0]           i_wdata,
    output logic [W-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/delta_pu_weight_buffer.sv
// Per-PU weight prefetch buffer: fetches ENTRIES words from the Weight SRAM
// through the controller handshake and streams them in order to the PEs.
module delta_pu_weight_buffer
    import delta_pkg::*;
#(
    parameter int unsigned ENTRIES = INPUT_CHANNEL,
    parameter int unsigned WORD_W  = WEIGHT_WORD_W,
    parameter int unsigned STRIDE  = MAX_WEIGHT_LEN_BYTE,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    delta_pu_weight_buffer_if.master bus
);

    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned IDXC_W = IDX_W + 1;
    localparam int unsigned FIFO_W = WORD_W + IDX_W;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    wbuf_state_t            r_state;
    logic [IDXC_W-1:0]      r_idx;
    logic                   r_read;
    logic [SRAM_ADDR_W-1:0] r_addr;
    logic                   r_done;
    logic                   r_err;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_head_valid;
    logic                   w_all_requested;
    logic                   w_final_pop;
    logic [FIFO_W-1:0]      w_head;
    logic [CNT_W-1:0]       w_count;
    logic [SRAM_ADDR_W-1:0] w_next_addr;

    assign w_head_valid    = (w_count != '0);
    assign w_pop           = w_head_valid && bus.w_ready;
    assign w_push          = (r_state == WB_REQ) && bus.WB_SRAM_ready && !bus.finish_cycle;
    assign w_all_requested = (r_idx == IDXC_W'(ENTRIES));
    // The last word can leave while still in GAP; done must follow that pop directly.
    assign w_final_pop     = w_pop && w_all_requested && (w_count == CNT_W'(1));
    assign w_next_addr     = SRAM_ADDR_W'(r_idx) * SRAM_ADDR_W'(STRIDE);

    delta_weight_fifo #(
        .DEPTH (DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .i_flush (bus.finish_cycle),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({bus.WB_SRAM_data, r_idx[IDX_W-1:0]}),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    // Fetch sequencer; read/address/done/err are registered alongside the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= WB_IDLE;
            r_idx   <= '0;
            r_read  <= 1'b0;
            r_addr  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.finish_cycle) begin
                r_state <= WB_IDLE;
                r_idx   <= '0;
                r_read  <= 1'b0;
            end else begin
                if (bus.WB_SRAM_ready && (r_state != WB_REQ)) begin
                    r_err <= 1'b1;
                end
                case (r_state)
                    WB_IDLE: begin
                        if (bus.start) begin
                            r_state <= WB_REQ;
                            r_idx   <= '0;
                            r_read  <= 1'b1;
                            r_addr  <= '0;
                        end
                    end
                    WB_REQ: begin
                        if (bus.WB_SRAM_ready) begin
                            r_state <= WB_GAP;
                            r_idx   <= r_idx + IDXC_W'(1);
                            r_read  <= 1'b0;
                        end
                    end
                    WB_GAP: begin
                        if (w_final_pop) begin
                            r_state <= WB_IDLE;
                            r_done  <= 1'b1;
                        end else if (w_all_requested) begin
                            r_state <= WB_DRAIN;
                        end else if (w_count < CNT_W'(DEPTH)) begin
                            r_state <= WB_REQ;
                            r_read  <= 1'b1;
                            r_addr  <= w_next_addr;
                        end
                    end
                    WB_DRAIN: begin
                        if (w_final_pop || !w_head_valid) begin
                            r_state <= WB_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= WB_IDLE;
                endcase
            end
        end
    end

    assign bus.WB_SRAM_read    = r_read;
    assign bus.WB_SRAM_address = r_addr;
    assign bus.w_valid         = w_head_valid;
    assign bus.w_data          = w_head[FIFO_W-1:IDX_W];
    assign bus.w_idx           = w_head[IDX_W-1:0];
    assign bus.w_last          = w_head_valid && (w_head[IDX_W-1:0] == IDX_W'(ENTRIES - 1));
    assign bus.busy            = (r_state != WB_IDLE);
    assign bus.done            = r_done;
    assign bus.err             = r_err;

endmodule

// File: tb/tb_delta_pu_weight_buffer.sv
// Randomized bench for delta_pu_weight_buffer: controller/PE environment plus
// an in-order queue model of the fetched words.
module tb_delta_pu_weight_buffer;

    localparam int ENTRIES = 16;
    localparam int STRIDE  = 8;
    localparam int DEPTH   = 4;

    typedef struct {
        logic [63:0] data;
        int          idx;
    } ent_t;

    logic clock;
    logic reset;

    delta_pu_weight_buffer_if #(.WORD_W(64), .IDX_W(4)) ifc ();

    delta_pu_weight_buffer #(
        .ENTRIES (ENTRIES),
        .WORD_W  (64),
        .STRIDE  (STRIDE),
        .DEPTH   (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // model state
    ent_t q[$];
    logic busy_m = 1'b0, done_m = 1'b0, err_m = 1'b0;
    int   req_k  = 0;

    // environment state and knobs
    int          ctl_wait   = -1;
    logic        ready_prev = 1'b0;
    logic [31:0] last_addr  = '0;
    logic [31:0] first_addr = '1;
    int          wr_pct = 100, lat_fixed = 0;
    logic        basic_data = 1'b0;
    logic        start_pend = 1'b0, finish_pend = 1'b0, stray_pend = 1'b0;
    logic        fin_k5 = 1'b0, fin_hit = 1'b0;

    // statistics
    int          nreq, npops, nlast, ndone, ncoinc;
    logic [63:0] pop_log [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr_stats();
        nreq = 0; npops = 0; nlast = 0; ndone = 0; ncoinc = 0; first_addr = '1;
        for (int i = 0; i < 16; i++) pop_log[i] = '0;
    endtask

    task automatic set_inputs_idle();
        ifc.start = 1'b0; ifc.finish_cycle = 1'b0; ifc.WB_SRAM_ready = 1'b0;
        ifc.WB_SRAM_data = '0; ifc.w_ready = 1'b0;
    endtask

    // Compare the DUT outputs (state after the last rising edge) with the model.
    task automatic sync();
        @(negedge clock);
        cyc++;
        chk("busy", 64'(ifc.busy), 64'(busy_m));
        chk("done", 64'(ifc.done), 64'(done_m));
        chk("err", 64'(ifc.err), 64'(err_m));
        chk("w_valid", 64'(ifc.w_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("w_data", ifc.w_data, q[0].data);
            chk("w_idx", 64'(ifc.w_idx), 64'(q[0].idx));
            chk("w_last", 64'(ifc.w_last), 64'(q[0].idx == ENTRIES - 1));
        end else begin
            chk("w_last_empty", 64'(ifc.w_last), 64'(0));
        end
        if (!busy_m) chk("read_idle", 64'(ifc.WB_SRAM_read), 64'(0));
        if (ifc.done) ndone++;
    endtask

    // Controller/PE reaction for this cycle, then the model's view of the next edge.
    task automatic drive();
        logic ready_d, finish_d, start_d, stray_d, busy_b, popped, done_n, wr;
        logic [63:0] data_d;
        int lat;
        ready_d = 1'b0; finish_d = 1'b0; start_d = 1'b0; stray_d = 1'b0; data_d = '0;
        if (ready_prev) begin
            chk("read_gap", 64'(ifc.WB_SRAM_read), 64'(0));
            ctl_wait = -1;
        end else if (ifc.WB_SRAM_read) begin
            if (ctl_wait < 0) begin
                chk("addr", 64'(ifc.WB_SRAM_address), 64'(req_k * STRIDE));
                chk("req_free_slot", 64'(q.size() < DEPTH), 64'(1));
                chk("req_in_range", 64'(req_k < ENTRIES), 64'(1));
                if (nreq == 0) first_addr = ifc.WB_SRAM_address;
                nreq++;
                last_addr = ifc.WB_SRAM_address;
                lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(4, 1));
                ctl_wait = lat - 1;
            end else begin
                chk("addr_hold", 64'(ifc.WB_SRAM_address), 64'(last_addr));
                ctl_wait--;
            end
            if (ctl_wait == 0) begin
                ready_d = 1'b1;
                data_d  = basic_data ? 64'(32'h100 + req_k) : {$urandom, $urandom};
            end
        end
        if (stray_pend && !ifc.WB_SRAM_read && !ready_prev) begin
            ready_d = 1'b1; stray_d = 1'b1; data_d = '1; stray_pend = 1'b0;
        end
        wr = (int'($urandom_range(99, 0)) < wr_pct);
        if (start_pend) begin start_d = 1'b1; start_pend = 1'b0; end
        if (finish_pend || (fin_k5 && ready_d && !stray_d && req_k == 5)) begin
            finish_d = 1'b1; finish_pend = 1'b0;
            if (fin_k5 && ready_d) begin fin_hit = 1'b1; fin_k5 = 1'b0; end
        end
        ifc.start = start_d; ifc.finish_cycle = finish_d; ifc.WB_SRAM_ready = ready_d;
        ifc.WB_SRAM_data = data_d; ifc.w_ready = wr;

        busy_b = busy_m; done_n = 1'b0; popped = 1'b0;
        if (finish_d) begin
            q.delete(); busy_m = 1'b0; req_k = 0; ctl_wait = -1;
        end else begin
            if (stray_d) err_m = 1'b1;
            if (wr && q.size() != 0) begin
                if (q[0].idx == ENTRIES - 1) begin done_n = 1'b1; busy_m = 1'b0; end
                if (npops < 16) pop_log[npops] = ifc.w_data;
                if (ifc.w_last) nlast++;
                npops++;
                void'(q.pop_front());
                popped = 1'b1;
            end
            if (ready_d && !stray_d) begin
                if (popped) ncoinc++;
                q.push_back('{data: data_d, idx: req_k});
                req_k++;
            end
            if (start_d && !busy_b) begin busy_m = 1'b1; req_k = 0; end
        end
        done_m = done_n;
        ready_prev = ready_d;
    endtask

    task automatic step();
        sync();
        drive();
    endtask

    task automatic run_to_idle(input int fin_permille);
        for (int i = 0; i < 3000 && busy_m; i++) begin
            if (fin_permille != 0 && int'($urandom_range(999, 0)) < fin_permille) finish_pend = 1'b1;
            step();
        end
        if (busy_m) chk("fetch_timeout", 64'(1), 64'(0));
        repeat (2) step();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_read"}, 64'(ifc.WB_SRAM_read), 64'(0));
        chk({tag, "_addr"}, 64'(ifc.WB_SRAM_address), 64'(0));
        chk({tag, "_valid"}, 64'(ifc.w_valid), 64'(0));
        chk({tag, "_data"}, ifc.w_data, 64'(0));
        chk({tag, "_idx"}, 64'(ifc.w_idx), 64'(0));
        chk({tag, "_last"}, 64'(ifc.w_last), 64'(0));
        chk({tag, "_busy"}, 64'(ifc.busy), 64'(0));
        chk({tag, "_done"}, 64'(ifc.done), 64'(0));
        chk({tag, "_err"}, 64'(ifc.err), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        set_inputs_idle();
        reset = 1'b1;
        #1 reset = 1'b0;
        #11;
        check_reset_values("reset");
        @(negedge clock);
        reset = 1'b1;

        // basic fetch: fixed latency, known data pattern, PE always ready
        clr_stats(); basic_data = 1'b1; lat_fixed = 3; wr_pct = 100;
        start_pend = 1'b1; step();
        chk("start_to_read", 64'(ifc.WB_SRAM_read), 64'(0));
        sync();
        chk("read_after_start", 64'(ifc.WB_SRAM_read), 64'(1));
        drive();
        run_to_idle(0);
        chk("basic_nreq", 64'(nreq), 64'(16));
        chk("basic_last_addr", 64'(last_addr), 64'(120));
        chk("basic_npops", 64'(npops), 64'(16));
        chk("basic_first_data", pop_log[0], 64'h100);
        chk("basic_mid_data", pop_log[7], 64'h107);
        chk("basic_last_data", pop_log[15], 64'h10F);
        chk("basic_nlast", 64'(nlast), 64'(1));
        chk("basic_ndone", 64'(ndone), 64'(1));
        basic_data = 1'b0;

        // backpressure: PE stalled, only DEPTH requests may go out
        clr_stats(); lat_fixed = 2; wr_pct = 0;
        start_pend = 1'b1; step();
        repeat (40) step();
        chk("bp_nreq", 64'(nreq), 64'(4));
        chk("bp_read_low", 64'(ifc.WB_SRAM_read), 64'(0));
        chk("bp_valid", 64'(ifc.w_valid), 64'(1));
        wr_pct = 100; lat_fixed = 0;
        run_to_idle(0);
        chk("bp_nreq_total", 64'(nreq), 64'(16));
        chk("bp_npops", 64'(npops), 64'(16));
        chk("bp_ndone", 64'(ndone), 64'(1));

        // simultaneous push/pop after filling the FIFO
        clr_stats(); lat_fixed = 1; wr_pct = 0;
        start_pend = 1'b1; step();
        repeat (20) step();
        wr_pct = 100;
        run_to_idle(0);
        chk("pp_overlap_seen", 64'(ncoinc != 0), 64'(1));
        chk("pp_npops", 64'(npops), 64'(16));

        // finish_cycle together with the ready for index 5
        clr_stats(); lat_fixed = 0; wr_pct = 100; fin_k5 = 1'b1; fin_hit = 1'b0;
        start_pend = 1'b1; step();
        for (int i = 0; i < 2000 && !fin_hit; i++) step();
        chk("fin_hit", 64'(fin_hit), 64'(1));
        sync();
        chk("fin_busy", 64'(ifc.busy), 64'(0));
        chk("fin_valid", 64'(ifc.w_valid), 64'(0));
        chk("fin_err", 64'(ifc.err), 64'(0));
        chk("fin_read", 64'(ifc.WB_SRAM_read), 64'(0));
        drive();
        repeat (3) step();
        chk("fin_ndone", 64'(ndone), 64'(0));

        // randomized fetches, some aborted by finish_cycle
        for (int t = 0; t < 6; t++) begin
            clr_stats(); lat_fixed = 0; wr_pct = int'($urandom_range(100, 20));
            start_pend = 1'b1; step();
            run_to_idle((t % 2 == 1) ? 5 : 0);
        end

        // stray ready in IDLE sets a sticky err; a following fetch still works
        clr_stats(); stray_pend = 1'b1;
        step(); step();
        chk("stray_err", 64'(ifc.err), 64'(1));
        wr_pct = 100;
        start_pend = 1'b1; step();
        run_to_idle(0);
        chk("stray_err_held", 64'(ifc.err), 64'(1));
        chk("stray_npops", 64'(npops), 64'(16));
        chk("stray_ndone", 64'(ndone), 64'(1));

        // async reset while draining
        clr_stats(); lat_fixed = 0; wr_pct = 0;
        start_pend = 1'b1; step();
        for (int i = 0; i < 1000 && req_k < ENTRIES; i++) begin
            wr_pct = (q.size() >= 2) ? 100 : 0;
            step();
        end
        wr_pct = 0;
        repeat (3) step();
        chk("drain_words_pending", 64'(ifc.w_valid), 64'(1));
        chk("drain_busy", 64'(ifc.busy), 64'(1));
        @(posedge clock);
        #3 reset = 1'b0;
        set_inputs_idle();
        #1;
        check_reset_values("async_reset");
        q.delete(); busy_m = 1'b0; done_m = 1'b0; err_m = 1'b0; req_k = 0;
        ctl_wait = -1; ready_prev = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        clr_stats(); wr_pct = 100;
        start_pend = 1'b1; step();
        run_to_idle(0);
        chk("post_reset_first_addr", 64'(first_addr), 64'(0));
        chk("post_reset_npops", 64'(npops), 64'(16));
        chk("post_reset_ndone", 64'(ndone), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
